// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with valid/ready handshake, synchronous flush and
// optional two-entry skid buffer (define MEM_WB_SKID_EN to enable the skid register).
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sel_dat_in,
  input  logic              sel_c_in,
  input  logic              we_v_in,
  input  logic              we_c_in,
  input  logic              sel_sto_in,
  input  logic [DATA_W-1:0] do_in,
  input  logic [BYTE_W-1:0] dob_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_AW-1:0] rg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_dat,
  output logic              sel_c,
  output logic              we_v,
  output logic              we_c,
  output logic              sel_sto,
  output logic [DATA_W-1:0] do_out,
  output logic [BYTE_W-1:0] dob,
  output logic [DATA_W-1:0] alu_result,
  output logic [REG_AW-1:0] rg
);

  typedef struct packed {
    logic              sel_dat;
    logic              sel_c;
    logic              we_v;
    logic              we_c;
    logic              sel_sto;
    logic [DATA_W-1:0] dat;
    logic [BYTE_W-1:0] byt;
    logic [DATA_W-1:0] alu;
    logic [REG_AW-1:0] rg;
  } wb_entry_t;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0] state_q, state_d;
  wb_entry_t  in_ent, main_q, main_d;
  logic       accept, xfer;

  assign in_ent = {sel_dat_in, sel_c_in, we_v_in, we_c_in, sel_sto_in,
                   do_in, dob_in, alu_result_in, rg_in};

  assign out_valid = (state_q != ST_EMPTY);
  assign xfer      = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

`ifdef MEM_WB_SKID_EN
  wb_entry_t skid_q, skid_d;
  logic      ready_q;

  // Registered ready: upstream never sees a path from out_ready.
  assign in_ready = ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_ent;
        end
      end
      ST_ONE: begin
        if (xfer && accept) begin
          main_d = in_ent;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_ent;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over everything; payload is left untouched and gated at the outputs.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_FULL);
    end
  end
`else
  // Without skid storage a new entry can only enter as the held one leaves.
  assign in_ready = !out_valid || out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_ent;
        end
      end
      ST_ONE: begin
        if (accept) begin
          main_d = in_ent;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: state_d = ST_EMPTY;
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end
`endif

  // Bubbles must never write the register file or flags.
  assign we_v       = main_q.we_v & out_valid;
  assign we_c       = main_q.we_c & out_valid;
  assign sel_dat    = main_q.sel_dat;
  assign sel_c      = main_q.sel_c;
  assign sel_sto    = main_q.sel_sto;
  assign do_out     = main_q.dat;
  assign dob        = main_q.byt;
  assign alu_result = main_q.alu;
  assign rg         = main_q.rg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed + random bench for mem_wb_stage; scoreboard queue holds entries the
// stage has accepted, popped and compared as they transfer out.
module tb_mem_wb_stage;

  typedef struct packed {
    logic        sd, sc, wv, wc, ss;
    logic [31:0] d;
    logic [7:0]  b;
    logic [31:0] a;
    logic [3:0]  r;
  } ent_t;

`ifdef MEM_WB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic sel_dat_in, sel_c_in, we_v_in, we_c_in, sel_sto_in;
  logic [31:0] do_in, alu_result_in, do_out, alu_result;
  logic [7:0]  dob_in, dob;
  logic [3:0]  rg_in, rg;
  logic sel_dat, sel_c, we_v, we_c, sel_sto;

  int checks = 0;
  int failures = 0;
  int xfers = 0;
  ent_t q[$];
  ent_t obs;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .BYTE_W(8), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .sel_dat_in(sel_dat_in), .sel_c_in(sel_c_in), .we_v_in(we_v_in),
    .we_c_in(we_c_in), .sel_sto_in(sel_sto_in),
    .do_in(do_in), .dob_in(dob_in), .alu_result_in(alu_result_in), .rg_in(rg_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sel_dat(sel_dat), .sel_c(sel_c), .we_v(we_v), .we_c(we_c), .sel_sto(sel_sto),
    .do_out(do_out), .dob(dob), .alu_result(alu_result), .rg(rg)
  );

  assign obs = {sel_dat, sel_c, we_v, we_c, sel_sto, do_out, dob, alu_result, rg};

  task automatic chk(input string tag, input logic [95:0] o, input logic [95:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic ent_t mk(input logic [4:0] c, input logic [31:0] d,
                              input logic [7:0] b, input logic [31:0] a, input logic [3:0] r);
    ent_t e;
    {e.sd, e.sc, e.wv, e.wc, e.ss} = c;
    e.d = d; e.b = b; e.a = a; e.r = r;
    return e;
  endfunction

  // One clock: drive at negedge, check just after, update the model at posedge.
  task automatic step(input logic v, input ent_t e, input logic ordy, input logic fl);
    logic exp_rdy, acc, xf;
    @(negedge clk);
    in_valid = v; out_ready = ordy; flush = fl;
    {sel_dat_in, sel_c_in, we_v_in, we_c_in, sel_sto_in, do_in, dob_in, alu_result_in, rg_in} = e;
    #1;
    exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || ordy);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) chk("entry", obs, q[0]);
    else chk("we_gate", {we_v, we_c}, 2'b00);
    acc = v && exp_rdy;
    xf  = (q.size() != 0) && ordy;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (xf) begin void'(q.pop_front()); xfers++; end
      if (acc) q.push_back(e);
    end
  endtask

  initial begin
    ent_t a, b, z;
    int n;
    z = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    {sel_dat_in, sel_c_in, we_v_in, we_c_in, sel_sto_in, do_in, dob_in, alu_result_in, rg_in} = '0;
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_outs", obs, z);
    @(negedge clk); rst_n = 1'b1;

    // Single pass
    a = mk(5'b10101, 32'h0EAB3321, 8'h12, 32'hEEEEEEEE, 4'd5);
    step(1'b1, a, 1'b1, 1'b0);
    step(1'b0, z, 1'b1, 1'b0);
    step(1'b0, z, 1'b1, 1'b0);
    chk("single_drain", q.size(), 0);

    // Backpressure
    b = mk(5'b01010, 32'h13572468, 8'h34, 32'h22222222, 4'd3);
    if (SKID) begin
      step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, b, 1'b0, 1'b0);
      step(1'b0, z, 1'b0, 1'b0);   // expects in_ready=0, outputs A
      step(1'b0, z, 1'b1, 1'b0);   // A leaves
      step(1'b0, z, 1'b1, 1'b0);   // B leaves
      step(1'b0, z, 1'b0, 1'b0);
    end else begin
      step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, b, 1'b0, 1'b0);   // refused: in_ready=0 with out_ready=0
      step(1'b1, b, 1'b1, 1'b0);   // replaces A in the same cycle
      step(1'b0, z, 1'b1, 1'b0);
    end
    chk("bp_drain", q.size(), 0);

    // Streaming 16 entries
    xfers = 0;
    for (int i = 0; i < 16; i++)
      step(1'b1, mk(5'(i), 32'hA000_0000 + 32'(i), 8'(i * 3), 32'(i * 7), 4'(i)), 1'b1, 1'b0);
    step(1'b0, z, 1'b1, 1'b0);
    chk("stream_count", xfers, 16);
    chk("stream_drain", q.size(), 0);

    // Flush with held entries and an incoming one
    step(1'b1, a, 1'b0, 1'b0);
    if (SKID) step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, mk(5'b11111, 32'hDEADBEEF, 8'hFF, 32'h1, 4'd9), 1'b1, 1'b1);
    step(1'b0, z, 1'b1, 1'b0);   // nothing may appear
    chk("flush_gate", {we_v, we_c}, 2'b00);
    chk("flush_ready", in_ready, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      n = int'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)),
           mk(5'($urandom), $urandom, 8'($urandom), $urandom, 4'($urandom)),
           1'($urandom_range(0, 3) != 0), n == 0);
    end
    step(1'b0, z, 1'b1, 1'b0);
    step(1'b0, z, 1'b1, 1'b0);
    step(1'b0, z, 1'b1, 1'b0);
    chk("rand_drain", q.size(), 0);

    // Asynchronous reset with an entry held
    step(1'b1, a, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_outs", obs, z);
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    step(1'b0, z, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
